fft_mult_sched: RTL and testbench

//  Stage/butterfly sequencer for the in-place radix-2 DIT FFT core.
//  - Generates data-RAM read addresses, twiddle-ROM addresses and the multiplier data_valid.
//  - Produces write-back addresses aligned to the butterfly result.
//  - Drains the pipeline between stages to avoid read-after-write hazards.
//  - Sits between the FFT top-level control and the RAM/ROM/complex-multiplier/butterfly datapath.
//  - Input RAM holds samples in bit-reversed order; reordering is out of scope.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_delay_line.sv | 23 ++
 rtl/fft_mult_sched.sv | 132 +++++++++++++
 tb/tb_fft_mult_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT core.
package fft_pkg;
  localparam int LOG2N_DEF    = 3;
  localparam int RD_LAT_DEF   = 1;
  localparam int MULT_LAT_DEF = 5;
  localparam int BF_LAT_DEF   = 1;
  localparam int CPLX_W       = 50;
  localparam int TW_W         = 36;

  typedef struct packed {
    logic [24:0] re;
    logic [24:0] im;
  } cplx_t;

  typedef struct packed {
    logic [17:0] re;
    logic [17:0] im;
  } tw_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fsm_t;
endpackage

// File: rtl/fft_delay_line.sv
// Reset-clearable shift register: q is d delayed by DEPTH clock cycles.
module fft_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/fft_mult_sched.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT: issues operand and
// twiddle reads, times the multiplier valid and write-back, drains between stages.
module fft_mult_sched
  import fft_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int BF_LAT   = BF_LAT_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       pause_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(LOG2N)-1:0]   stage_o,
  output logic                       rd_en_o,
  output logic [LOG2N-1:0]           rd_addr_a_o,
  output logic [LOG2N-1:0]           rd_addr_b_o,
  output logic [LOG2N-2:0]           tw_addr_o,
  output logic                       mult_valid_o,
  output logic                       wr_en_o,
  output logic [LOG2N-1:0]           wr_addr_a_o,
  output logic [LOG2N-1:0]           wr_addr_b_o
);
  localparam int TOT = RD_LAT + MULT_LAT + BF_LAT;
  localparam int SW  = $clog2(LOG2N);
  localparam int BW  = LOG2N - 1;
  localparam int CW  = $clog2(TOT + (1 << (LOG2N - 1)) + 1);
  localparam logic [BW-1:0]    LAST_B = '1;
  localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

  fsm_t          state;
  logic [SW-1:0] stage;
  logic [BW-1:0] bfly;
  logic [CW-1:0] inflight;
  logic          issue;
  logic          last_wr;
  logic [LOG2N-1:0] span, pos, addr_a, tw_full;

  // Issue handshake: a butterfly is issued (rd_en_o) on any ISSUE cycle with
  // pause_i low; the datapath has no backpressure, so every issue completes.
  assign issue   = (state == ISSUE) && !pause_i;
  assign last_wr = (state == DRAIN) && wr_en_o && (inflight == CW'(1));

  // Group base is b with its low s bits cleared, doubled; pos stays in place.
  always_comb begin
    span    = ONE << stage;
    pos     = LOG2N'(bfly) & (span - ONE);
    addr_a  = ((LOG2N'(bfly) & ~(span - ONE)) << 1) | pos;
    tw_full = pos << (BW - int'(stage));
  end

  assign rd_en_o     = issue;
  assign rd_addr_a_o = issue ? addr_a : '0;
  assign rd_addr_b_o = issue ? (addr_a + span) : '0;
  assign tw_addr_o   = issue ? tw_full[BW-1:0] : '0;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign stage_o     = stage;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      stage <= '0;
      bfly  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= ISSUE;
            stage <= '0;
            bfly  <= '0;
          end
        end
        ISSUE: begin
          if (!pause_i) begin
            if (bfly == LAST_B) begin
              bfly  <= '0;
              state <= DRAIN;
            end else begin
              bfly <= bfly + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (last_wr) begin
            if (stage == LAST_S) begin
              state <= DONE;
            end else begin
              stage <= stage + SW'(1);
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          stage <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= '0;
    end else begin
      case ({rd_en_o, wr_en_o})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  fft_delay_line #(.W(1 + 2 * LOG2N), .DEPTH(TOT)) u_wr_line (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     ({rd_en_o, rd_addr_a_o, rd_addr_b_o}),
    .q     ({wr_en_o, wr_addr_a_o, wr_addr_b_o})
  );

  fft_delay_line #(.W(1), .DEPTH(RD_LAT)) u_mv_line (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (rd_en_o),
    .q     (mult_valid_o)
  );
endmodule

// File: tb/tb_fft_mult_sched.sv
// Scoreboard bench for fft_mult_sched: an N=8 instance under start/pause/reset
// scenarios and an N=16 instance running one full transform.
module tb_fft_mult_sched;
  localparam int TOT = 7;

  logic clk = 1'b0;
  logic rst, rst4, start, start4, pause;

  logic       busy, done, rd_en, mv, wr;
  logic [1:0] stage, tw;
  logic [2:0] ra, rb, wa, wb;

  logic       busy4, done4, rd_en4, mv4, wr4;
  logic [1:0] stage4;
  logic [2:0] tw4;
  logic [3:0] ra4, rb4, wa4, wb4;

  fft_mult_sched #(.LOG2N(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause),
    .busy_o(busy), .done_o(done), .stage_o(stage),
    .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb), .tw_addr_o(tw),
    .mult_valid_o(mv), .wr_en_o(wr), .wr_addr_a_o(wa), .wr_addr_b_o(wb)
  );

  fft_mult_sched #(.LOG2N(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .start_i(start4), .pause_i(1'b0),
    .busy_o(busy4), .done_o(done4), .stage_o(stage4),
    .rd_en_o(rd_en4), .rd_addr_a_o(ra4), .rd_addr_b_o(rb4), .tw_addr_o(tw4),
    .mult_valid_o(mv4), .wr_en_o(wr4), .wr_addr_a_o(wa4), .wr_addr_b_o(wb4)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state, index 0 = N=8 instance, 1 = N=16 instance
  int     chk = 0, fails = 0;
  longint exp_q[2][$];
  longint wr_q[2][$];
  longint mv_q[2][$];
  int     rd_seen[2], t0[2], pause_len[2], done_cnt[2];
  bit     prev_done[2];

  task automatic check(input string name, input longint act, input longint exp);
    chk++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    chk++;
    fails++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
  endtask

  // Reference: butterfly b of stage s pairs a and a+2^s inside groups of 2^(s+1).
  function automatic longint ref_pack(input int lg, input int s, input int b);
    int span, grp, pos, a, twa;
    span = 2 ** s;
    grp  = b / span;
    pos  = b % span;
    a    = grp * 2 * span + pos;
    twa  = pos * (2 ** (lg - 1 - s));
    return longint'(s) * 4096 + a * 256 + (a + span) * 16 + twa;
  endfunction

  task automatic new_xform(input int k, input int lg);
    exp_q[k].delete();
    wr_q[k].delete();
    mv_q[k].delete();
    rd_seen[k]   = 0;
    pause_len[k] = 0;
    for (int s = 0; s < lg; s++)
      for (int b = 0; b < 2 ** (lg - 1); b++)
        exp_q[k].push_back(ref_pack(lg, s, b));
  endtask

  task automatic mon(input int k, input int lg, input bit rdv, input int a, input int b,
                     input int t, input int st, input bit mvv, input bit wrv, input int wa_v,
                     input int wb_v, input bit dn, input bit bs, input bit ps);
    longint e;
    if (rdv) begin
      check("rd_during_pause", ps, 0);
      if (exp_q[k].size() == 0) flag("rd_unexpected");
      else begin
        e = exp_q[k].pop_front();
        check("rd_stage_addr_tw", longint'(st) * 4096 + a * 256 + b * 16 + t, e);
      end
      if (rd_seen[k] == 0) t0[k] = cyc;
      rd_seen[k]++;
      wr_q[k].push_back(longint'(cyc + TOT) * 65536 + a * 256 + b);
      mv_q[k].push_back(cyc + 1);
    end
    if (mvv) begin
      if (mv_q[k].size() == 0) flag("mv_unexpected");
      else check("mv_cycle", cyc, mv_q[k].pop_front());
    end
    if (wrv) begin
      if (wr_q[k].size() == 0) flag("wr_unexpected");
      else check("wr_cycle_addr", longint'(cyc) * 65536 + wa_v * 256 + wb_v, wr_q[k].pop_front());
    end
    if (prev_done[k]) begin
      check("busy_after_done", bs, 0);
      check("done_width", dn, 0);
    end
    if (dn) begin
      done_cnt[k]++;
      check("busy_at_done", bs, 1);
      check("done_cycle", cyc, t0[k] + lg * (2 ** (lg - 1) + TOT) + pause_len[k]);
    end
    prev_done[k] = dn;
  endtask

  // Monitor
  always @(negedge clk) begin
    mon(0, 3, rd_en, ra, rb, tw, stage, mv, wr, wa, wb, done, busy, pause);
    mon(1, 4, rd_en4, ra4, rb4, tw4, stage4, mv4, wr4, wa4, wb4, done4, busy4, 1'b0);
  end

  // Driver tasks
  task automatic pulse(input int k);
    if (k == 0) start = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_rd(input int k, input int n);
    int t = 0;
    while (rd_seen[k] < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_rd", rd_seen[k] >= n, 1);
  endtask

  task automatic wait_done(input int k, input int n);
    int t = 0;
    while (done_cnt[k] < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_done", done_cnt[k] >= n, 1);
  endtask

  task automatic drained(input int k);
    check("drained_rd", exp_q[k].size(), 0);
    check("drained_wr", wr_q[k].size(), 0);
    check("drained_mv", mv_q[k].size(), 0);
  endtask

  initial begin
    int dc, t;
    rst = 1'b1; rst4 = 1'b1; start = 1'b0; start4 = 1'b0; pause = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_seen[k] = 0; t0[k] = 0; pause_len[k] = 0; done_cnt[k] = 0; prev_done[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, stage, rd_en, ra, rb, tw, mv, wr, wa, wb}, 0);
    check("reset_outputs4", {busy4, done4, stage4, rd_en4, ra4, rb4, tw4, mv4, wr4, wa4, wb4}, 0);
    rst = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    // Plain transforms on both sizes
    new_xform(0, 3);
    new_xform(1, 4);
    start = 1'b1;
    pulse(1);
    wait_done(0, 1);
    wait_done(1, 1);
    repeat (3) @(posedge clk);
    #1;
    drained(0);
    drained(1);

    // Pause for a random 1..3 cycles (first run exactly 3) after the 2nd stage-1 issue
    for (int r = 0; r < 2; r++) begin
      new_xform(0, 3);
      pulse(0);
      wait_rd(0, 6);
      pause_len[0] = (r == 0) ? 3 : $urandom_range(1, 3);
      pause = 1'b1;
      repeat (pause_len[0]) @(posedge clk);
      #1;
      pause = 1'b0;
      wait_done(0, 2 + r);
      repeat (3) @(posedge clk);
      #1;
      drained(0);
    end

    // Start pulses during DRAIN and DONE must be ignored
    dc = done_cnt[0];
    new_xform(0, 3);
    pulse(0);
    wait_rd(0, 4);
    repeat (2) @(posedge clk);
    #1;
    pulse(0);
    t = 0;
    while (!done && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", done, 1);
    pulse(0);
    repeat (30) @(posedge clk);
    #1;
    check("single_done", done_cnt[0], dc + 1);
    drained(0);

    // Reset in the middle of stage 1, then a fresh transform
    new_xform(0, 3);
    pulse(0);
    wait_rd(0, 4 + $urandom_range(2, 3));
    rst = 1'b1;
    exp_q[0].delete();
    wr_q[0].delete();
    mv_q[0].delete();
    @(negedge clk);
    check("reset_abort", {busy, done, stage, rd_en, ra, rb, tw, mv, wr, wa, wb}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    dc = done_cnt[0];
    new_xform(0, 3);
    pulse(0);
    wait_done(0, dc + 1);
    repeat (3) @(posedge clk);
    #1;
    drained(0);
    drained(1);

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
